// File: rtl/mem_banked_pkg.sv
// Shared constants and types for the banked byte memory and its loader.
package mem_banked_pkg;

    // Loader session states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } ld_state_t;

    localparam int unsigned BANK_DEPTH = 32768;
    localparam int unsigned IDX_W      = $clog2(BANK_DEPTH);

    localparam logic [15:0] ROM_BASE_DEF = 16'h4000;
    localparam logic [15:0] ROM_END_DEF  = 16'h7FFF;

    // One write port request into a single bank
    typedef struct packed {
        logic             we;
        logic [IDX_W-1:0] idx;
        logic [7:0]       data;
    } bank_wr_t;

    // Inclusive byte-address range test
    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/mem_bank.sv
// Single 32768 x 8 synchronous RAM, write-first, registered read data.
// The array itself is never reset; only the read register is.
module mem_bank
    import mem_banked_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  bank_wr_t         wr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_data
);

    logic [7:0] mem [BANK_DEPTH];

    // Array write port
    always_ff @(posedge clk) begin
        if (wr.we) mem[wr.idx] <= wr.data;
    end

    // Read register; a same-cycle write to the read index bypasses the array
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          rd_data <= 8'h00;
        else if (wr.we && wr.idx == rd_idx)  rd_data <= wr.data;
        else                                 rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/mem_banked.sv
// Two-bank byte memory (even/odd byte lanes) with CPU write protection
// and a streaming loader that owns both banks while it runs.
module mem_banked
    import mem_banked_pkg::*;
#(
    parameter logic [15:0] ROM_BASE = ROM_BASE_DEF,
    parameter logic [15:0] ROM_END  = ROM_END_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] mem_read_addr_even,
    input  logic [14:0] mem_read_addr_odd,
    output logic [7:0]  mem_read_data_even,
    output logic [7:0]  mem_read_data_odd,
    input  logic [14:0] mem_write_addr_even,
    input  logic [14:0] mem_write_addr_odd,
    input  logic [7:0]  mem_write_data_even,
    input  logic [7:0]  mem_write_data_odd,
    input  logic        mem_write_en_even,
    input  logic        mem_write_en_odd,
    input  logic        load_start,
    input  logic [15:0] load_addr,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    output logic        load_ready,
    input  logic        load_done,
    output logic        cpu_hold,
    output logic        wp_fault,
    input  logic        wp_fault_clr
);

    localparam int NUM_BANKS = 2;

    ld_state_t   state, state_nxt;
    logic [15:0] ptr, ptr_nxt;
    logic        ld_wr;

    // Lane 0 is the even bank, lane 1 the odd bank
    logic [NUM_BANKS-1:0][IDX_W-1:0] rd_idx, cpu_idx;
    logic [NUM_BANKS-1:0][7:0]       cpu_data, rd_data;
    logic [NUM_BANKS-1:0]            cpu_we, viol;

    assign rd_idx   = {mem_read_addr_odd,   mem_read_addr_even};
    assign cpu_idx  = {mem_write_addr_odd,  mem_write_addr_even};
    assign cpu_data = {mem_write_data_odd,  mem_write_data_even};
    assign cpu_we   = {mem_write_en_odd,    mem_write_en_even};

    assign mem_read_data_even = rd_data[0];
    assign mem_read_data_odd  = rd_data[1];

    assign load_ready = (state == LOAD);
    assign ld_wr      = load_ready & load_valid;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic     prot;
        bank_wr_t wr;

        assign prot    = in_range({cpu_idx[b], 1'(b)}, ROM_BASE, ROM_END);
        assign viol[b] = (state == IDLE) & cpu_we[b] & prot;

        // Port mux: the loader owns the banks outside IDLE, CPU writes are dropped then
        always_comb begin
            wr = '0;
            if (state != IDLE) begin
                wr.we   = ld_wr & (ptr[0] == 1'(b));
                wr.idx  = ptr[15:1];
                wr.data = load_data;
            end else begin
                wr.we   = cpu_we[b] & ~prot;
                wr.idx  = cpu_idx[b];
                wr.data = cpu_data[b];
            end
        end

        mem_bank u_bank (
            .clk     (clk),
            .reset   (reset),
            .wr      (wr),
            .rd_idx  (rd_idx[b]),
            .rd_data (rd_data[b])
        );
    end

    // Loader state, byte pointer and CPU hold register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= 16'h0000;
            cpu_hold <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            cpu_hold <= (state_nxt != IDLE);
        end
    end

    // Loader next state; a byte presented with load_done is still written
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = LOAD;
                    ptr_nxt   = load_addr;
                end
            end
            LOAD: begin
                if (load_valid) ptr_nxt = ptr + 16'd1;
                if (load_done)  state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sticky protection fault; a new violation beats a clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            wp_fault <= 1'b0;
        else if (|viol)        wp_fault <= 1'b1;
        else if (wp_fault_clr) wp_fault <= 1'b0;
    end

endmodule

// File: tb/tb_mem_banked.sv
// Directed + randomized bench for mem_banked against a byte-array model.
module tb_mem_banked;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] ra [2];
    logic [7:0]  rd [2];
    logic [14:0] wa [2];
    logic [7:0]  wd [2];
    logic        we [2];
    logic        load_start, load_valid, load_ready, load_done;
    logic [15:0] load_addr;
    logic [7:0]  load_data;
    logic        cpu_hold, wp_fault, wp_fault_clr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_banked dut (
        .clk                 (clk),
        .reset               (reset),
        .mem_read_addr_even  (ra[0]),
        .mem_read_addr_odd   (ra[1]),
        .mem_read_data_even  (rd[0]),
        .mem_read_data_odd   (rd[1]),
        .mem_write_addr_even (wa[0]),
        .mem_write_addr_odd  (wa[1]),
        .mem_write_data_even (wd[0]),
        .mem_write_data_odd  (wd[1]),
        .mem_write_en_even   (we[0]),
        .mem_write_en_odd    (we[1]),
        .load_start          (load_start),
        .load_addr           (load_addr),
        .load_valid          (load_valid),
        .load_data           (load_data),
        .load_ready          (load_ready),
        .load_done           (load_done),
        .cpu_hold            (cpu_hold),
        .wp_fault            (wp_fault),
        .wp_fault_clr        (wp_fault_clr)
    );

    // Reference model: flat 64 KiB byte space plus loader session mode
    logic [7:0] mref  [65536];
    bit         known [65536];
    int         mmode;          // 0 idle, 1 loading, 2 draining
    logic [15:0] mptr;
    bit         mfault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_rom(input logic [15:0] a);
        return a >= 16'h4000 && a <= 16'h7FFF;
    endfunction

    task automatic idle_inputs();
        for (int b = 0; b < 2; b++) begin
            wa[b] = '0; wd[b] = '0; we[b] = 1'b0;
        end
        load_start = 0; load_addr = '0; load_valid = 0; load_data = '0;
        load_done = 0; wp_fault_clr = 0;
    endtask

    // Advance one clock, apply the same inputs to the model, compare outputs
    task automatic step();
        bit          viol;
        logic [15:0] a;
        @(posedge clk);
        #1;
        viol = 0;
        if (mmode == 0) begin
            for (int b = 0; b < 2; b++) if (we[b]) begin
                a = {wa[b], b[0]};
                if (is_rom(a)) viol = 1;
                else begin mref[a] = wd[b]; known[a] = 1; end
            end
        end else if (mmode == 1 && load_valid) begin
            mref[mptr] = load_data; known[mptr] = 1;
            mptr = mptr + 16'd1;
        end
        if (viol)              mfault = 1;
        else if (wp_fault_clr) mfault = 0;
        case (mmode)
            0: if (load_start) begin mmode = 1; mptr = load_addr; end
            1: if (load_done) mmode = 2;
            default: mmode = 0;
        endcase
        chk("wp_fault",   wp_fault,   mfault);
        chk("cpu_hold",   cpu_hold,   mmode != 0);
        chk("load_ready", load_ready, mmode == 1);
        for (int b = 0; b < 2; b++) begin
            a = {ra[b], b[0]};
            if (known[a]) chk(b ? "rd_odd" : "rd_even", rd[b], mref[a]);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_even"}, rd[0], 8'h00);
        chk({tag, "_rd_odd"},  rd[1], 8'h00);
        chk({tag, "_ready"},   load_ready, 1'b0);
        chk({tag, "_hold"},    cpu_hold, 1'b0);
        chk({tag, "_wp"},      wp_fault, 1'b0);
    endtask

    function automatic logic [14:0] rnd_idx();
        case ($urandom_range(0, 2))
            0:       return 15'($urandom_range(0, 15));
            1:       return 15'h2000 + 15'($urandom_range(0, 7));
            default: return 15'h3FF8 + 15'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        mmode = 0; mptr = '0; mfault = 0;
        idle_inputs();
        ra[0] = '0; ra[1] = '0;
        reset = 1'b0;
        #2;
        chk_reset_outputs("por");
        #10 reset = 1'b1;

        // Even write outside ROM, read back next cycle
        we[0] = 1; wa[0] = 15'h0100; wd[0] = 8'hA5;
        step();
        idle_inputs(); ra[0] = 15'h0100;
        step();
        chk("even_rdbk", rd[0], 8'hA5);
        chk("even_wp",   wp_fault, 1'b0);

        // Same-cycle odd write and read: write-first
        we[1] = 1; wa[1] = 15'h0010; wd[1] = 8'h3C; ra[1] = 15'h0010;
        step();
        chk("odd_wfirst", rd[1], 8'h3C);
        idle_inputs();

        // Protected write dropped, fault set, then cleared
        ra[0] = 15'h2000;
        step();
        we[0] = 1; wa[0] = 15'h2000; wd[0] = 8'hEE;
        step();
        chk("rom_fault", wp_fault, 1'b1);
        idle_inputs();
        step();
        if (known[16'h4000]) chk("rom_keep", rd[0], mref[16'h4000]);
        else                 chk("rom_nobypass", rd[0] == 8'hEE, 1'b0);
        wp_fault_clr = 1;
        step();
        chk("rom_clr", wp_fault, 1'b0);
        // Violation in the same cycle as a clear keeps the flag
        we[1] = 1; wa[1] = 15'h3FFF; wp_fault_clr = 1;
        step();
        chk("viol_beats_clr", wp_fault, 1'b1);
        idle_inputs(); wp_fault_clr = 1;
        step();
        idle_inputs();

        // Loader wrapping from 0xFFFF to 0x0000
        load_start = 1; load_addr = 16'hFFFF;
        step();
        chk("wrap_hold_load", cpu_hold, 1'b1);
        load_start = 0; load_valid = 1; load_data = 8'h11;
        we[0] = 1; wa[0] = 15'h0005; wd[0] = 8'h99;   // dropped while loading
        step();
        load_data = 8'h22; we[0] = 0;
        step();
        load_valid = 0; load_done = 1; load_start = 1; load_addr = 16'h1234;
        step();
        chk("wrap_hold_drain", cpu_hold, 1'b1);
        chk("wrap_ready_drain", load_ready, 1'b0);
        idle_inputs();
        step();
        chk("wrap_hold_idle", cpu_hold, 1'b0);
        ra[1] = 15'h7FFF; ra[0] = 15'h0000;
        step();
        chk("wrap_ffff", rd[1], 8'h11);
        chk("wrap_0000", rd[0], 8'h22);
        chk("load_no_wp", wp_fault, 1'b0);

        // Byte presented together with load_done is still written
        load_start = 1; load_addr = 16'h0300;
        step();
        load_start = 0; load_valid = 1; load_data = 8'h5A; load_done = 1;
        step();
        chk("done_drain_hold", cpu_hold, 1'b1);
        idle_inputs();
        step();
        chk("done_idle_hold", cpu_hold, 1'b0);
        ra[0] = 15'h0180;
        step();
        chk("done_byte", rd[0], 8'h5A);

        // Reset mid-session: async clear, written bytes survive
        we[0] = 1; wa[0] = 15'h2001;           // set a fault first
        step();
        idle_inputs(); load_start = 1; load_addr = 16'h0400; ra[0] = 15'h0100;
        step();
        load_start = 0; load_valid = 1; load_data = 8'h77;
        step();
        load_data = 8'h88;
        step();
        chk("pre_rst_rd", rd[0], 8'hA5);
        chk("pre_rst_wp", wp_fault, 1'b1);
        #3 reset = 1'b0;
        #1 chk_reset_outputs("arst");
        idle_inputs();
        mmode = 0; mptr = '0; mfault = 0;
        @(posedge clk); #1;
        chk_reset_outputs("arst_hold");
        #2 reset = 1'b1;
        ra[0] = 15'h0200; ra[1] = 15'h0200;
        step();
        chk("rst_keep_even", rd[0], 8'h77);
        chk("rst_keep_odd",  rd[1], 8'h88);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < 2; b++) begin
                ra[b] = ($urandom_range(0, 3) == 0) ? wa[b] : rnd_idx();
                wa[b] = rnd_idx();
                wd[b] = 8'($urandom);
                we[b] = $urandom_range(0, 1);
            end
            load_start   = ($urandom_range(0, 19) == 0);
            load_addr    = {rnd_idx(), 1'($urandom)};
            load_valid   = $urandom_range(0, 1);
            load_data    = 8'($urandom);
            load_done    = ($urandom_range(0, 9) == 0);
            wp_fault_clr = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
